// File: rtl/tt_um_bmsce_tdm_demux_if.sv
// Tile pin bundle for the TDM demultiplexer.
// The master side drives the dedicated inputs; the slave side (the demux)
// drives the output pins and the bidirectional output enables.
interface tt_um_bmsce_tdm_demux_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_bmsce_tdm_demux.sv
// Two-channel serial TDM demultiplexer (tile top).
// Serial bits arrive on a strobed line, are assembled MSB-first into words and
// routed to channel A or B, each with a holding register, a valid/ack
// handshake and a sticky overrun flag.
// Optional build macro TDM_DEMUX_PARITY_EN: each frame carries one trailing
// even-parity bit; bad frames are dropped and flagged on par_err.
module tt_um_bmsce_tdm_demux #(
  parameter int WORD_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tt_um_bmsce_tdm_demux_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  // Input conditioning
  logic [7:0] sync_pipe [SYNC_STAGES];
  logic [7:0] ui_s;
  logic       sel_s;
  logic       din_s;
  logic       stb_s;
  logic       mode_s;
  logic       fs_s;
  logic       ack_a_s;
  logic       ack_b_s;
  logic       clr_s;

  // Edge history, ordered {ack_b, ack_a, frame_sync, strobe}
  logic [3:0] edge_hist;
  logic       stb_pls;
  logic       fs_pls;
  logic       ack_a_pls;
  logic       ack_b_pls;

  // Assembly and channel state
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_nxt;
  logic [FRAME_W-1:0] frame_shift;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  ch_a;
  logic [WORD_W-1:0]  ch_a_nxt;
  logic [WORD_W-1:0]  ch_b;
  logic [WORD_W-1:0]  ch_b_nxt;
  logic               valid_a;
  logic               valid_a_nxt;
  logic               valid_b;
  logic               valid_b_nxt;
  logic               ovr_a;
  logic               ovr_a_nxt;
  logic               ovr_b;
  logic               ovr_b_nxt;
  logic               ptr;
  logic               ptr_nxt;
  logic               par_ok;
  logic               complete;
  logic               to_a;
  logic               par_err;
  logic               busy;
`ifdef TDM_DEMUX_PARITY_EN
  logic               par_err_nxt;
`endif

  // Tile enable and bidirectional inputs carry no function here
  logic unused_pins;
  assign unused_pins = &{1'b0, bus.ena, bus.uio_in};

  // Synchronizer chain for every ui_in bit, sel included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_pipe[i] <= '0;
      end
    end else begin
      sync_pipe[0] <= bus.ui_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_pipe[i] <= sync_pipe[i-1];
      end
    end
  end

  assign ui_s    = sync_pipe[SYNC_STAGES-1];
  assign sel_s   = ui_s[0];
  assign din_s   = ui_s[1];
  assign stb_s   = ui_s[2];
  assign mode_s  = ui_s[3];
  assign fs_s    = ui_s[4];
  assign ack_a_s = ui_s[5];
  assign ack_b_s = ui_s[6];
  assign clr_s   = ui_s[7];

  // Edge history keeps tracking the pins through clear, so a line that is
  // already high when clear drops does not fake a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_hist <= '0;
    end else begin
      edge_hist <= {ack_b_s, ack_a_s, fs_s, stb_s};
    end
  end

  assign stb_pls   = stb_s   & ~edge_hist[0];
  assign fs_pls    = fs_s    & ~edge_hist[1];
  assign ack_a_pls = ack_a_s & ~edge_hist[2];
  assign ack_b_pls = ack_b_s & ~edge_hist[3];

  // Next-state: ack first, then frame_sync / strobe assembly and routing,
  // with clear overriding everything in the same cycle.
  always_comb begin
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    ch_a_nxt    = ch_a;
    ch_b_nxt    = ch_b;
    valid_a_nxt = valid_a;
    valid_b_nxt = valid_b;
    ovr_a_nxt   = ovr_a;
    ovr_b_nxt   = ovr_b;
    ptr_nxt     = ptr;
`ifdef TDM_DEMUX_PARITY_EN
    par_err_nxt = par_err;
`endif

    frame_shift = {shreg[FRAME_W-2:0], din_s};
`ifdef TDM_DEMUX_PARITY_EN
    word   = frame_shift[FRAME_W-1:1];
    par_ok = ~^frame_shift;
`else
    word   = frame_shift;
    par_ok = 1'b1;
`endif

    // frame_sync on the same cycle swallows the strobe bit
    complete = stb_pls && !fs_pls && (cnt == CNT_W'(FRAME_W - 1));
    to_a     = mode_s ? ptr : sel_s;

    // An ack that lands with a completing word frees the slot for that word
    if (ack_a_pls) begin
      valid_a_nxt = 1'b0;
    end
    if (ack_b_pls) begin
      valid_b_nxt = 1'b0;
    end

    if (fs_pls) begin
      shreg_nxt = '0;
      cnt_nxt   = '0;
      ptr_nxt   = 1'b1;
    end else if (stb_pls) begin
      if (complete) begin
        shreg_nxt = '0;
        cnt_nxt   = '0;
        // Alternation advances on every finished frame, kept or dropped
        if (mode_s) begin
          ptr_nxt = ~ptr;
        end
        if (par_ok) begin
          if (to_a) begin
            if (valid_a_nxt) begin
              ovr_a_nxt = 1'b1;
            end else begin
              ch_a_nxt    = word;
              valid_a_nxt = 1'b1;
            end
          end else begin
            if (valid_b_nxt) begin
              ovr_b_nxt = 1'b1;
            end else begin
              ch_b_nxt    = word;
              valid_b_nxt = 1'b1;
            end
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        else begin
          par_err_nxt = 1'b1;
        end
`endif
      end else begin
        shreg_nxt = frame_shift;
        cnt_nxt   = cnt + CNT_W'(1);
      end
    end

    if (clr_s) begin
      shreg_nxt   = '0;
      cnt_nxt     = '0;
      ch_a_nxt    = '0;
      ch_b_nxt    = '0;
      valid_a_nxt = 1'b0;
      valid_b_nxt = 1'b0;
      ovr_a_nxt   = 1'b0;
      ovr_b_nxt   = 1'b0;
      ptr_nxt     = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_nxt = 1'b0;
`endif
    end
  end

  // Demux state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      ch_a    <= '0;
      ch_b    <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      ovr_a   <= 1'b0;
      ovr_b   <= 1'b0;
      ptr     <= 1'b1;
    end else begin
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      ch_a    <= ch_a_nxt;
      ch_b    <= ch_b_nxt;
      valid_a <= valid_a_nxt;
      valid_b <= valid_b_nxt;
      ovr_a   <= ovr_a_nxt;
      ovr_b   <= ovr_b_nxt;
      ptr     <= ptr_nxt;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Sticky parity error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= par_err_nxt;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign busy = (cnt != '0);

  assign bus.uo_out  = {ch_b, ch_a};
  assign bus.uio_out = {1'b0, busy, par_err, ptr, ovr_b, ovr_a, valid_b, valid_a};
  assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_bmsce_tdm_demux.sv
// Self-checking bench for tt_um_bmsce_tdm_demux: directed scenarios followed
// by random pin-level events, compared against a word-level reference model.
module tb_tt_um_bmsce_tdm_demux;
  localparam int WORD_W      = 4;
  localparam int SYNC_STAGES = 2;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int SETTLE = SYNC_STAGES + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tt_um_bmsce_tdm_demux_if bus ();

  tt_um_bmsce_tdm_demux #(
    .WORD_W      (WORD_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: channel contents, flags and the pending frame bits
  bit [3:0] m_ch_a, m_ch_b;
  bit       m_va, m_vb, m_oa, m_ob, m_ptr, m_perr;
  bit       m_mode, m_sel;
  int       m_bits[$];

  function automatic void m_reset();
    m_ch_a = 0; m_ch_b = 0;
    m_va = 0; m_vb = 0; m_oa = 0; m_ob = 0;
    m_ptr = 1; m_perr = 0;
    m_bits.delete();
  endfunction

  function automatic void m_frame_sync();
    m_bits.delete();
    m_ptr = 1;
  endfunction

  function automatic void m_strobe(bit b, bit aa, bit ab);
    int  word = 0;
    int  ones = 0;
    bit  good = 1;
    bit  to_a;
    if (aa) m_va = 0;
    if (ab) m_vb = 0;
    m_bits.push_back(int'(b));
    if (m_bits.size() == FRAME_W) begin
      for (int i = 0; i < WORD_W; i++) word = word * 2 + m_bits[i];
      foreach (m_bits[i]) ones += m_bits[i];
`ifdef TDM_DEMUX_PARITY_EN
      good = (ones % 2) == 0;
`endif
      to_a = m_mode ? m_ptr : m_sel;
      if (!good) m_perr = 1;
      else if (to_a) begin
        if (m_va) m_oa = 1;
        else begin m_ch_a = 4'(word); m_va = 1; end
      end else begin
        if (m_vb) m_ob = 1;
        else begin m_ch_b = 4'(word); m_vb = 1; end
      end
      if (m_mode) m_ptr = !m_ptr;
      m_bits.delete();
    end
  endfunction

  function automatic logic [7:0] exp_uio();
    return {1'b0, m_bits.size() != 0, m_perr, m_ptr, m_ob, m_oa, m_vb, m_va};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".uo"},  bus.uo_out,  {m_ch_b, m_ch_a});
    chk({tag, ".uio"}, bus.uio_out, exp_uio());
    chk({tag, ".oe"},  bus.uio_oe,  8'hFF);
  endtask

  // One strobed bit; outputs must be unchanged after SYNC_STAGES edges and
  // updated on the next one.
  task automatic send_bit(input bit b, input bit aa = 0, input bit ab = 0,
                          input string tag = "bit");
    bus.ui_in[1] = b;
    tick(1);
    bus.ui_in[2] = 1'b1;
    bus.ui_in[5] = aa;
    bus.ui_in[6] = ab;
    tick(SYNC_STAGES);
    check_state({tag, ".pre"});
    m_strobe(b, aa, ab);
    tick(1);
    check_state({tag, ".post"});
    tick(1);
    bus.ui_in[2] = 1'b0;
    bus.ui_in[5] = 1'b0;
    bus.ui_in[6] = 1'b0;
    tick(SETTLE);
  endtask

  task automatic send_word(input bit [3:0] w, input bit ack_a_last = 0,
                           input string tag = "word");
    bit [7:0] fr;
`ifdef TDM_DEMUX_PARITY_EN
    fr = {3'b000, w, ^w};
`else
    fr = {4'b0000, w};
`endif
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      send_bit(fr[i], ack_a_last && (i == 0), 1'b0, tag);
    end
  endtask

  task automatic pulse_ack(input bit to_a);
    bus.ui_in[to_a ? 5 : 6] = 1'b1;
    tick(SETTLE);
    if (to_a) m_va = 0; else m_vb = 0;
    check_state(to_a ? "ack_a" : "ack_b");
    bus.ui_in[to_a ? 5 : 6] = 1'b0;
    tick(SETTLE);
  endtask

  task automatic pulse_fs(input bit with_strobe);
    bus.ui_in[1] = 1'($urandom_range(0, 1));
    tick(1);
    bus.ui_in[4] = 1'b1;
    if (with_strobe) bus.ui_in[2] = 1'b1;
    tick(SETTLE);
    m_frame_sync();
    check_state(with_strobe ? "fs_stb" : "fs");
    bus.ui_in[4] = 1'b0;
    bus.ui_in[2] = 1'b0;
    tick(SETTLE);
  endtask

  task automatic set_mode(input bit v);
    bus.ui_in[3] = v; m_mode = v; tick(SETTLE);
  endtask

  task automatic set_sel(input bit v);
    bus.ui_in[0] = v; m_sel = v; tick(SETTLE);
  endtask

  task automatic do_clear();
    bus.ui_in[7] = 1'b1;
    tick(SYNC_STAGES);
    check_state("clr.pre");
    m_reset();
    tick(1);
    check_state("clr.post");
    bus.ui_in[7] = 1'b0;
    tick(SETTLE);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'h00;
    m_mode = 0; m_sel = 0;
    m_reset();
    tick(2);
    check_state("reset");
    chk("reset.ptr", bus.uio_out[4], 1'b1);
    rst_n = 1'b1;
    tick(SETTLE);

    // Manual mode to A, word 1011
    set_sel(1);
    send_word(4'hB, 0, "tp1");
    chk("tp1.ch_a", bus.uo_out[3:0], 4'hB);
    chk("tp1.valid_a", bus.uio_out[0], 1'b1);
    chk("tp1.ch_b", bus.uo_out[7:4], 4'h0);
    chk("tp1.valid_b", bus.uio_out[1], 1'b0);

    // Auto alternation and overrun on A
    pulse_ack(1);
    set_mode(1);
    send_word(4'h3, 0, "auto1");
    send_word(4'hC, 0, "auto2");
    chk("auto.ch_a", bus.uo_out[3:0], 4'h3);
    chk("auto.ch_b", bus.uo_out[7:4], 4'hC);
    chk("auto.ptr", bus.uio_out[4], 1'b1);
    send_word(4'h5, 0, "auto3");
    chk("auto.keep_a", bus.uo_out[3:0], 4'h3);
    chk("auto.ovr_a", bus.uio_out[2], 1'b1);

    // Build valid_a=1, ovr_b=1, ptr=0 and then clear
    send_word(4'h6, 0, "auto4");
    send_word(4'h1, 0, "auto5");
    chk("preclr.ovr_b", bus.uio_out[3], 1'b1);
    chk("preclr.ptr", bus.uio_out[4], 1'b0);
    do_clear();
    chk("clr.uo", bus.uo_out, 8'h00);
    chk("clr.uio", bus.uio_out, 8'h10);

    // Ack coinciding with a completing word to A
    send_word(4'h2, 0, "coA1");
    send_word(4'h4, 0, "coB");
    send_word(4'hE, 1, "coA2");
    chk("co.ch_a", bus.uo_out[3:0], 4'hE);
    chk("co.valid_a", bus.uio_out[0], 1'b1);
    chk("co.ovr_a", bus.uio_out[2], 1'b0);

    // Partial word discarded by frame_sync
    set_mode(0);
    set_sel(1);
    pulse_ack(1);
    send_bit(1, 0, 0, "part");
    send_bit(1, 0, 0, "part");
    pulse_fs(0);
    chk("fs.busy", bus.uio_out[6], 1'b0);
    send_word(4'h9, 0, "fsw");
    chk("fs.ch_a", bus.uo_out[3:0], 4'h9);
    chk("fs.busy_after", bus.uio_out[6], 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
    pulse_ack(1);
    send_bit(0); send_bit(1); send_bit(1); send_bit(1); send_bit(1, 0, 0, "par_ok");
    chk("par.ch_a", bus.uo_out[3:0], 4'h7);
    chk("par.valid_a", bus.uio_out[0], 1'b1);
    chk("par.err0", bus.uio_out[5], 1'b0);
    pulse_ack(1);
    send_bit(0); send_bit(1); send_bit(1); send_bit(1); send_bit(0, 0, 0, "par_bad");
    chk("par.err1", bus.uio_out[5], 1'b1);
    chk("par.valid_kept", bus.uio_out[0], 1'b0);
`else
    chk("nopar.err", bus.uio_out[5], 1'b0);
`endif

    // Asynchronous reset in the middle of a word
    send_bit(1, 0, 0, "mid");
    send_bit(0, 0, 0, "mid");
    chk("mid.busy", bus.uio_out[6], 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(SETTLE);

    // Random pin-level events
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      send_bit(1'($urandom_range(0, 1)),
                                $urandom_range(0, 9) == 0,
                                $urandom_range(0, 9) == 0, "rbit");
      else if (r < 63) pulse_ack(1);
      else if (r < 71) pulse_ack(0);
      else if (r < 76) pulse_fs(0);
      else if (r < 80) pulse_fs(1);
      else if (r < 86) set_mode(!m_mode);
      else if (r < 92) set_sel(!m_sel);
      else if (r < 95) do_clear();
      else             send_word(4'($urandom_range(0, 15)),
                                 $urandom_range(0, 3) == 0, "rword");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
